// File: rtl/float_encoder_pipe.sv
// Two-stage IEEE-754 encoder: S1 biases/classifies the operand, S2 rounds to nearest-even and packs.
// Define FLOAT_ENCODER_SUBNORMAL_EN to produce gradual underflow; otherwise tiny results flush to zero.
module float_encoder_pipe #(
  parameter int unsigned FSIZE = 64,
  localparam int unsigned EXP_SIZE  = (FSIZE == 16) ? 5  : (FSIZE == 32) ? 8  : 11,
  localparam int unsigned MANT_SIZE = (FSIZE == 16) ? 10 : (FSIZE == 32) ? 23 : 52
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_SIZE+1:0]   in_exp,
  input  logic [MANT_SIZE+1:0]  in_frac,
  input  logic                  in_sticky,
  input  logic                  in_zero,
  input  logic                  in_inf,
  input  logic                  in_nan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FSIZE-1:0]      out_bits,
  output logic [3:0]            out_flags
);

  // One spare bit over the operand exponent so biasing and the rounding carry never wrap.
  localparam int unsigned EW   = EXP_SIZE + 3;
  localparam int unsigned VW   = MANT_SIZE + 3;
  localparam int unsigned BIAS = (1 << (EXP_SIZE - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_SIZE) - 1;

  typedef struct packed {
    logic                 sign;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic                 tiny;
    logic [EW-1:0]        eb;
    logic [MANT_SIZE-1:0] mant;
    logic                 guard;
    logic                 rnd;
    logic                 sticky;
  } s1_t;

  logic                 adv;
  logic                 s1_valid_q;
  s1_t                  s1_q, s1_d;
  logic                 out_valid_q;
  logic [FSIZE-1:0]     out_bits_q, out_bits_d;
  logic [3:0]           out_flags_q, out_flags_d;
  logic [EW-1:0]        eb_c;

  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_flags = out_flags_q;

  assign eb_c = {in_exp[EXP_SIZE+1], in_exp} + EW'(BIAS);

`ifdef FLOAT_ENCODER_SUBNORMAL_EN
  localparam int unsigned SW = $clog2(VW + 1);

  logic [EW-1:0] sh_full;
  logic [SW-1:0] sh_amt;
  logic [VW-1:0] sub_src, sub_vec, sub_mask;
  logic          sub_lost;

  // Denormalizing shifter; only meaningful when eb <= 0, where 1 - eb is a small positive count.
  always_comb begin
    sh_full  = EW'(1) - eb_c;
    sh_amt   = (sh_full > EW'(VW)) ? SW'(VW) : SW'(sh_full);
    sub_src  = {1'b1, in_frac};
    sub_vec  = sub_src >> sh_amt;
    sub_mask = (VW'(1) << sh_amt) - VW'(1);
    sub_lost = |(sub_src & sub_mask);
  end
`endif

  // Stage 1: bias, classify, and (optionally) denormalize.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.nan    = in_nan;
    s1_d.inf    = in_inf;
    s1_d.zero   = in_zero;
    s1_d.eb     = eb_c;
    s1_d.tiny   = eb_c[EW-1] | (eb_c == '0);
    s1_d.mant   = in_frac[MANT_SIZE+1:2];
    s1_d.guard  = in_frac[1];
    s1_d.rnd    = in_frac[0];
    s1_d.sticky = in_sticky;
`ifdef FLOAT_ENCODER_SUBNORMAL_EN
    if (s1_d.tiny) begin
      s1_d.mant   = sub_vec[MANT_SIZE+1:2];
      s1_d.guard  = sub_vec[1];
      s1_d.rnd    = sub_vec[0];
      s1_d.sticky = in_sticky | sub_lost;
    end
`endif
  end

  logic                 up, inexact, carry;
  logic [MANT_SIZE:0]   mant_r;
  logic [EW-1:0]        eb_f;

  // Stage 2: round to nearest-even, then pack by class (nan > inf > zero > tiny > normal).
  always_comb begin
    up          = s1_q.guard & (s1_q.rnd | s1_q.sticky | s1_q.mant[0]);
    inexact     = s1_q.guard | s1_q.rnd | s1_q.sticky;
    mant_r      = {1'b0, s1_q.mant} + (MANT_SIZE+1)'(up);
    carry       = mant_r[MANT_SIZE];
    eb_f        = s1_q.eb + EW'(carry);
    out_bits_d  = {s1_q.sign, eb_f[EXP_SIZE-1:0], mant_r[MANT_SIZE-1:0]};
    out_flags_d = {2'b00, inexact, 1'b0};
    if (s1_q.nan) begin
      out_bits_d  = {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(MANT_SIZE-1){1'b0}}};
      out_flags_d = 4'b0001;
    end else if (s1_q.inf) begin
      out_bits_d  = {s1_q.sign, {EXP_SIZE{1'b1}}, {MANT_SIZE{1'b0}}};
      out_flags_d = 4'b0000;
    end else if (s1_q.zero) begin
      out_bits_d  = {s1_q.sign, {(FSIZE-1){1'b0}}};
      out_flags_d = 4'b0000;
    end else if (s1_q.tiny) begin
`ifdef FLOAT_ENCODER_SUBNORMAL_EN
      out_bits_d  = {s1_q.sign, {(EXP_SIZE-1){1'b0}}, carry, mant_r[MANT_SIZE-1:0]};
      out_flags_d = {1'b0, inexact, inexact, 1'b0};
`else
      out_bits_d  = {s1_q.sign, {(FSIZE-1){1'b0}}};
      out_flags_d = 4'b0110;
`endif
    end else if (!eb_f[EW-1] && (eb_f >= EW'(EMAX))) begin
      out_bits_d  = {s1_q.sign, {EXP_SIZE{1'b1}}, {MANT_SIZE{1'b0}}};
      out_flags_d = 4'b1010;
    end
  end

  // Both stages advance together; results hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (in_valid) begin
        s1_q <= s1_d;
      end
      if (s1_valid_q) begin
        out_bits_q  <= out_bits_d;
        out_flags_q <= out_flags_d;
      end
    end
  end

endmodule
